// File: rtl/down_timer_pkg.sv
// Shared types and constants for the down_timer block.
package down_timer_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/down_cnt_core.sv
// Count/reload datapath: loads a value, decrements, or restores the captured reload value.
module down_cnt_core
    import down_timer_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             dec,
    input  logic             reload_sel,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] count,
    output logic             is_one_c
);

    logic [WIDTH-1:0] reload;

    // load has priority; reload is only ever captured together with a load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            reload <= '0;
        end else if (load) begin
            count  <= din;
            reload <= din;
        end else if (reload_sel) begin
            count  <= reload;
        end else if (dec && (count != '0)) begin
            count  <= count - WIDTH'(1);
        end
    end

    assign is_one_c = (count == WIDTH'(1));

endmodule

// File: rtl/down_timer.sv
// Programmable down-counting timer with pause, abort and optional auto-reload.
module down_timer
    import down_timer_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             start,
    input  logic             stop,
    input  logic             auto,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    state_t state;
    state_t state_next;
    logic   start_ok;
    logic   is_one;
    logic   load;
    logic   dec;
    logic   reload_sel;
    logic   tc_next;

    assign start_ok = start && (din != '0);

    down_cnt_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .dec        (dec),
        .reload_sel (reload_sel),
        .din        (din),
        .count      (count),
        .is_one_c   (is_one)
    );

    // State register; status flags are registered from the next state so they track state exactly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            tc    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            tc    <= tc_next;
            busy  <= (state_next == RUN);
            done  <= (state_next == DONE);
        end
    end

    // Next-state: stop beats start beats counting
    always_comb begin
        state_next = state;
        if (stop) begin
            state_next = IDLE;
        end else if (start_ok) begin
            state_next = RUN;
        end else if ((state == RUN) && en && is_one) begin
            state_next = auto ? RUN : DONE;
        end
    end

    // Datapath controls and terminal-count request
    always_comb begin
        load       = 1'b0;
        dec        = 1'b0;
        reload_sel = 1'b0;
        tc_next    = 1'b0;
        if (stop) begin
            load = 1'b0;
        end else if (start_ok) begin
            load = 1'b1;
        end else if ((state == RUN) && en) begin
            if (is_one) begin
                tc_next    = 1'b1;
                reload_sel = auto;
                dec        = !auto;
            end else begin
                dec = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_down_timer.sv
// Randomized plus directed bench for down_timer against a behavioural timer model.
module tb_down_timer;

    localparam int unsigned W = 8;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic         start;
    logic         stop;
    logic         auto;
    logic [W-1:0] din;
    logic [W-1:0] count;
    logic         busy;
    logic         tc;
    logic         done;

    int total;
    int bad;

    int m_state;
    int m_count;
    int m_reload;
    int m_tc;

    down_timer #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .start (start),
        .stop  (stop),
        .auto  (auto),
        .din   (din),
        .count (count),
        .busy  (busy),
        .tc    (tc),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state  = M_IDLE;
        m_count  = 0;
        m_reload = 0;
        m_tc     = 0;
    endtask

    // One clock edge of the timer as described behaviourally
    task automatic model_step(input bit e, input bit s, input bit p, input bit a, input int d);
        m_tc = 0;
        if (p) begin
            m_state = M_IDLE;
        end else if (s && d != 0) begin
            m_count  = d;
            m_reload = d;
            m_state  = M_RUN;
        end else if (m_state == M_RUN && e) begin
            if (m_count == 1) begin
                m_tc = 1;
                if (a) begin
                    m_count = m_reload;
                end else begin
                    m_count = 0;
                    m_state = M_DONE;
                end
            end else begin
                m_count = m_count - 1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".count"}, 32'(count), 32'(m_count));
        check({tag, ".busy"},  32'(busy),  32'(m_state == M_RUN));
        check({tag, ".done"},  32'(done),  32'(m_state == M_DONE));
        check({tag, ".tc"},    32'(tc),    32'(m_tc));
    endtask

    task automatic cyc(input string tag, input bit e, input bit s, input bit p, input bit a, input int d);
        en    = e;
        start = s;
        stop  = p;
        auto  = a;
        din   = W'(d);
        @(posedge clk);
        model_step(e, s, p, a, d);
        #1;
        check_all(tag);
    endtask

    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check({tag, ".count0"}, 32'(count), 32'd0);
        check({tag, ".busy0"},  32'(busy),  32'd0);
        check({tag, ".done0"},  32'(done),  32'd0);
        check({tag, ".tc0"},    32'(tc),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int tc_seen;
    int tc_gap;

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        en    = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        auto  = 1'b0;
        din   = '0;
        model_reset();
        #3;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // single shot of 5
        cyc("s5", 1, 1, 0, 0, 5);
        check("s5.first", 32'(count), 32'd5);
        tc_seen = 0;
        for (int i = 0; i < 5; i++) begin
            cyc("s5", 1, 0, 0, 0, 0);
            if (tc) tc_seen++;
        end
        check("s5.tc_at_zero", 32'(tc), 32'd1);
        check("s5.tc_count", 32'(tc_seen), 32'd1);
        cyc("s5", 1, 0, 0, 0, 0);
        check("s5.done", 32'(done), 32'd1);

        // auto reload of 3, tc period exactly 3
        cyc("a3", 1, 1, 0, 1, 3);
        tc_seen = 0;
        tc_gap  = 0;
        for (int i = 0; i < 12; i++) begin
            cyc("a3", 1, 0, 0, 1, 0);
            tc_gap++;
            if (tc) begin
                if (tc_seen > 0) check("a3.period", 32'(tc_gap), 32'd3);
                tc_seen++;
                tc_gap = 0;
            end
        end
        check("a3.pulses", 32'(tc_seen), 32'd4);
        cyc("a3", 1, 0, 1, 0, 0);

        // pause at count 2 for two cycles
        cyc("p4", 1, 1, 0, 0, 4);
        cyc("p4", 1, 0, 0, 0, 0);
        cyc("p4", 1, 0, 0, 0, 0);
        check("p4.at2", 32'(count), 32'd2);
        cyc("p4", 0, 0, 0, 0, 9);
        cyc("p4", 0, 0, 0, 0, 7);
        check("p4.hold", 32'(count), 32'd2);
        cyc("p4", 1, 0, 0, 0, 0);
        cyc("p4", 1, 0, 0, 0, 0);
        check("p4.tc_late", 32'(tc), 32'd1);

        // zero start ignored, start+stop aborts to idle holding count
        cyc("z", 1, 0, 1, 0, 0);
        cyc("z", 1, 1, 0, 0, 0);
        check("z.idle", 32'(busy), 32'd0);
        cyc("ss", 1, 1, 0, 0, 6);
        cyc("ss", 1, 0, 0, 0, 0);
        cyc("ss", 1, 1, 1, 0, 9);
        check("ss.held", 32'(count), 32'd5);
        check("ss.idle", 32'(busy), 32'd0);

        // async reset at count 3
        cyc("r8", 1, 1, 0, 0, 8);
        for (int i = 0; i < 5; i++) cyc("r8", 1, 0, 0, 0, 0);
        check("r8.at3", 32'(count), 32'd3);
        async_reset("r8");
        for (int i = 0; i < 4; i++) cyc("r8post", 1, 0, 0, 0, 0);

        // long count restarted at 100
        cyc("big", 1, 1, 0, 0, 255);
        for (int i = 0; i < 155; i++) cyc("big", 1, 0, 0, 0, 0);
        check("big.at100", 32'(count), 32'd100);
        cyc("big", 1, 1, 0, 0, 2);
        check("big.restart", 32'(count), 32'd2);
        cyc("big", 1, 0, 0, 0, 0);
        cyc("big", 1, 0, 0, 0, 0);
        check("big.tc", 32'(tc), 32'd1);

        // random traffic
        for (int i = 0; i < 800; i++) begin
            bit e, s, p, a;
            int d;
            e = ($urandom_range(0, 9) < 8);
            s = ($urandom_range(0, 9) == 0);
            p = ($urandom_range(0, 39) == 0);
            a = (((i / 64) % 2) == 1) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 7) == 0);
            d = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 12));
            if ($urandom_range(0, 199) == 0) begin
                async_reset("rnd");
            end else begin
                cyc("rnd", e, s, p, a, d);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
